// File: rtl/sc_microsequencer.sv
// Microsequencer for a SPARC-like datapath: fetch/decode/execute FSM driving
// register-file write index, bus A/B source selects and ALU opcode.
module sc_microsequencer #(
    parameter int DATAWIDTH_DECODER_SELECTION = 6,
    parameter int DATAWIDTH_MUX_SELECTION     = 6,
    parameter int DATAWIDTH_ALU_SELECTION     = 4,
    parameter logic [5:0] REG_PC     = 6'd32,
    parameter logic [5:0] REG_FOUR   = 6'd33,
    parameter logic [5:0] REG_SIMM13 = 6'd34,
    parameter logic [5:0] REG_DISP   = 6'd35,
    parameter logic [3:0] ALU_ADD    = 4'b0000,
    parameter logic [3:0] ALU_PASSA  = 4'b1111
) (
    input  logic                                   SC_MICROSEQUENCER_CLOCK_50,
    input  logic                                   SC_MICROSEQUENCER_Reset_InLow,
    input  logic                                   SC_MICROSEQUENCER_SingleStep_In,
    input  logic                                   SC_MICROSEQUENCER_Step_InLow,
    input  logic                                   SC_MICROSEQUENCER_Overflow_InLow,
    input  logic                                   SC_MICROSEQUENCER_Carry_InLow,
    input  logic                                   SC_MICROSEQUENCER_Negative_InLow,
    input  logic                                   SC_MICROSEQUENCER_Zero_InLow,
    input  logic [1:0]                             SC_MICROSEQUENCER_RegIR_OP,
    input  logic [4:0]                             SC_MICROSEQUENCER_RegIR_RD,
    input  logic [5:0]                             SC_MICROSEQUENCER_RegIR_OP3,
    input  logic [4:0]                             SC_MICROSEQUENCER_RegIR_RS1,
    input  logic                                   SC_MICROSEQUENCER_RegIR_BIT13,
    input  logic [4:0]                             SC_MICROSEQUENCER_RegIR_RS2,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_MICROSEQUENCER_DecoderSelectionWrite_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQUENCER_MUXSelectionBUSA_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_MICROSEQUENCER_MUXSelectionBUSB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_MICROSEQUENCER_ALUSelection_Out,
    output logic                                   SC_MICROSEQUENCER_RegIRLoad_OutLow,
    output logic [2:0]                             SC_MICROSEQUENCER_State_Out,
    output logic                                   SC_MICROSEQUENCER_Illegal_Out
);

    typedef enum logic [2:0] {
        ST_WAIT     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC_ALU = 3'd3,
        ST_BRANCH   = 3'd4,
        ST_INCPC    = 3'd5,
        ST_PCLOAD   = 3'd6
    } state_t;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } flags_t;

    state_t state, state_next;
    flags_t flags;
    logic   illegal;
    logic   taken;
    logic   rst_n;
    logic   run_mode;

    assign rst_n    = SC_MICROSEQUENCER_Reset_InLow;
    assign run_mode = !SC_MICROSEQUENCER_SingleStep_In;

    always_ff @(posedge SC_MICROSEQUENCER_CLOCK_50) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state   <= ST_WAIT;
            flags   <= '0;
            illegal <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_EXEC_ALU && SC_MICROSEQUENCER_RegIR_OP3[4])
                flags <= '{v: !SC_MICROSEQUENCER_Overflow_InLow,
                           c: !SC_MICROSEQUENCER_Carry_InLow,
                           n: !SC_MICROSEQUENCER_Negative_InLow,
                           z: !SC_MICROSEQUENCER_Zero_InLow};
            if (state == ST_DECODE && SC_MICROSEQUENCER_RegIR_OP != 2'b10
                                   && SC_MICROSEQUENCER_RegIR_OP != 2'b00)
                illegal <= 1'b1;
        end
    end

    // Branch condition field RD[3:0] evaluated against the registered flags.
    always_comb begin
        taken = 1'b0;
        case (SC_MICROSEQUENCER_RegIR_RD[3:0])
            4'b1000: taken = 1'b1;
            4'b0001: taken = flags.z;
            4'b1001: taken = !flags.z;
            4'b0101: taken = flags.c;
            4'b0110: taken = flags.n;
            4'b0111: taken = flags.v;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves a variable unassigned, which would infer a latch.
        state_next = ST_WAIT;
        SC_MICROSEQUENCER_DecoderSelectionWrite_Out = '0;
        SC_MICROSEQUENCER_MUXSelectionBUSA_Out      = '0;
        SC_MICROSEQUENCER_MUXSelectionBUSB_Out      = '0;
        SC_MICROSEQUENCER_ALUSelection_Out          = ALU_PASSA;
        SC_MICROSEQUENCER_RegIRLoad_OutLow          = 1'b1;
        case (state)
            ST_WAIT: begin
                state_next = (run_mode || !SC_MICROSEQUENCER_Step_InLow) ? ST_FETCH : ST_WAIT;
            end
            ST_FETCH: begin
                SC_MICROSEQUENCER_MUXSelectionBUSA_Out = DATAWIDTH_MUX_SELECTION'(REG_PC);
                SC_MICROSEQUENCER_RegIRLoad_OutLow     = 1'b0;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                case (SC_MICROSEQUENCER_RegIR_OP)
                    2'b10:   state_next = ST_EXEC_ALU;
                    2'b00:   state_next = ST_BRANCH;
                    default: state_next = ST_INCPC;
                endcase
            end
            ST_EXEC_ALU: begin
                SC_MICROSEQUENCER_MUXSelectionBUSA_Out =
                    DATAWIDTH_MUX_SELECTION'(SC_MICROSEQUENCER_RegIR_RS1);
                SC_MICROSEQUENCER_MUXSelectionBUSB_Out = SC_MICROSEQUENCER_RegIR_BIT13
                    ? DATAWIDTH_MUX_SELECTION'(REG_SIMM13)
                    : DATAWIDTH_MUX_SELECTION'(SC_MICROSEQUENCER_RegIR_RS2);
                SC_MICROSEQUENCER_ALUSelection_Out =
                    DATAWIDTH_ALU_SELECTION'(SC_MICROSEQUENCER_RegIR_OP3[3:0]);
                SC_MICROSEQUENCER_DecoderSelectionWrite_Out =
                    DATAWIDTH_DECODER_SELECTION'(SC_MICROSEQUENCER_RegIR_RD);
                state_next = ST_INCPC;
            end
            ST_BRANCH: begin
                state_next = taken ? ST_PCLOAD : ST_INCPC;
            end
            ST_INCPC, ST_PCLOAD: begin
                SC_MICROSEQUENCER_MUXSelectionBUSA_Out = DATAWIDTH_MUX_SELECTION'(REG_PC);
                SC_MICROSEQUENCER_MUXSelectionBUSB_Out = (state == ST_PCLOAD)
                    ? DATAWIDTH_MUX_SELECTION'(REG_DISP)
                    : DATAWIDTH_MUX_SELECTION'(REG_FOUR);
                SC_MICROSEQUENCER_ALUSelection_Out          = ALU_ADD;
                SC_MICROSEQUENCER_DecoderSelectionWrite_Out =
                    DATAWIDTH_DECODER_SELECTION'(REG_PC);
                state_next = run_mode ? ST_FETCH : ST_WAIT;
            end
            default: state_next = ST_WAIT;
        endcase
        // A register write on the reset edge would corrupt PC; suppress it.
        if (!rst_n)
            SC_MICROSEQUENCER_DecoderSelectionWrite_Out = '0;
    end

    assign SC_MICROSEQUENCER_State_Out   = state;
    assign SC_MICROSEQUENCER_Illegal_Out = illegal;

endmodule

// File: tb/tb_sc_microsequencer.sv
// Self-checking bench for sc_microsequencer: per-cycle expected outputs are
// queued as stimulus is driven and compared at the following falling edge.
module tb_sc_microsequencer;

    logic       clk = 1'b0;
    logic       rst_n, single, step_n, v_n, c_n, n_n, z_n;
    logic [1:0] op;
    logic [4:0] rd, rs1, rs2;
    logic [5:0] op3;
    logic       bit13;
    logic [5:0] wr, ma, mb;
    logic [3:0] alu;
    logic       irl;
    logic [2:0] st;
    logic       ill;

    always #5 clk = ~clk;

    sc_microsequencer dut (
        .SC_MICROSEQUENCER_CLOCK_50                 (clk),
        .SC_MICROSEQUENCER_Reset_InLow              (rst_n),
        .SC_MICROSEQUENCER_SingleStep_In            (single),
        .SC_MICROSEQUENCER_Step_InLow               (step_n),
        .SC_MICROSEQUENCER_Overflow_InLow           (v_n),
        .SC_MICROSEQUENCER_Carry_InLow              (c_n),
        .SC_MICROSEQUENCER_Negative_InLow           (n_n),
        .SC_MICROSEQUENCER_Zero_InLow               (z_n),
        .SC_MICROSEQUENCER_RegIR_OP                 (op),
        .SC_MICROSEQUENCER_RegIR_RD                 (rd),
        .SC_MICROSEQUENCER_RegIR_OP3                (op3),
        .SC_MICROSEQUENCER_RegIR_RS1                (rs1),
        .SC_MICROSEQUENCER_RegIR_BIT13              (bit13),
        .SC_MICROSEQUENCER_RegIR_RS2                (rs2),
        .SC_MICROSEQUENCER_DecoderSelectionWrite_Out(wr),
        .SC_MICROSEQUENCER_MUXSelectionBUSA_Out     (ma),
        .SC_MICROSEQUENCER_MUXSelectionBUSB_Out     (mb),
        .SC_MICROSEQUENCER_ALUSelection_Out         (alu),
        .SC_MICROSEQUENCER_RegIRLoad_OutLow         (irl),
        .SC_MICROSEQUENCER_State_Out                (st),
        .SC_MICROSEQUENCER_Illegal_Out              (ill)
    );

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [5:0] wr, ma, mb;
        logic [3:0] alu;
        logic       irl;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic exp_ill  = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
    endtask

    function automatic exp_t mk(input string tag, input logic [2:0] s, input logic [5:0] w,
                                input logic [5:0] a, input logic [5:0] b, input logic [3:0] f,
                                input logic l);
        exp_t e;
        e.tag = tag; e.st = s; e.wr = w; e.ma = a; e.mb = b; e.alu = f; e.irl = l;
        e.ill = exp_ill;
        return e;
    endfunction

    function automatic exp_t idle(input string tag, input logic [2:0] s);
        return mk(tag, s, 6'd0, 6'd0, 6'd0, 4'hF, 1'b1);
    endfunction

    // One clock: queue the expectation, compare on the falling edge, advance.
    task automatic cyc(input exp_t e);
        exp_t g;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        check({g.tag, ".state"}, 32'(st),  32'(g.st));
        check({g.tag, ".write"}, 32'(wr),  32'(g.wr));
        check({g.tag, ".muxa"},  32'(ma),  32'(g.ma));
        check({g.tag, ".muxb"},  32'(mb),  32'(g.mb));
        check({g.tag, ".alu"},   32'(alu), 32'(g.alu));
        check({g.tag, ".irld"},  32'(irl), 32'(g.irl));
        check({g.tag, ".ill"},   32'(ill), 32'(g.ill));
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction starting at its FETCH cycle; 'taken' is the branch
    // outcome the test author expects from the flag history.
    task automatic run_instr(input string tag, input logic [1:0] o, input logic [5:0] o3,
                             input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                             input logic b13, input logic taken);
        op = o; op3 = o3; rs1 = r1; rs2 = r2; rd = d; bit13 = b13;
        cyc(mk({tag, ".fetch"}, 3'd1, 6'd0, 6'd32, 6'd0, 4'hF, 1'b0));
        cyc(idle({tag, ".decode"}, 3'd2));
        if (o == 2'b10) begin
            cyc(mk({tag, ".exec"}, 3'd3, {1'b0, d}, {1'b0, r1},
                   b13 ? 6'd34 : {1'b0, r2}, o3[3:0], 1'b1));
            cyc(mk({tag, ".incpc"}, 3'd5, 6'd32, 6'd32, 6'd33, 4'h0, 1'b1));
        end else if (o == 2'b00) begin
            cyc(idle({tag, ".branch"}, 3'd4));
            if (taken) cyc(mk({tag, ".pcload"}, 3'd6, 6'd32, 6'd32, 6'd35, 4'h0, 1'b1));
            else       cyc(mk({tag, ".incpc"},  3'd5, 6'd32, 6'd32, 6'd33, 4'h0, 1'b1));
        end else begin
            exp_ill = 1'b1;
            cyc(mk({tag, ".incpc"}, 3'd5, 6'd32, 6'd32, 6'd33, 4'h0, 1'b1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; single = 1'b0; step_n = 1'b1;
        v_n = 1'b1; c_n = 1'b1; n_n = 1'b1; z_n = 1'b1;
        op = 2'b10; op3 = '0; rs1 = '0; rs2 = '0; rd = '0; bit13 = 1'b0;
        @(posedge clk);
        #1;
        cyc(idle("reset", 3'd0));
        rst_n = 1'b1;
        cyc(idle("release", 3'd0));

        run_instr("add",      2'b10, 6'b000000, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        z_n = 1'b0;
        run_instr("subcc_z",  2'b10, 6'b010000, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0);
        z_n = 1'b1;
        run_instr("be_t",     2'b00, 6'd0, 5'd0, 5'd0, 5'b00001, 1'b0, 1'b1);
        run_instr("bne_nt",   2'b00, 6'd0, 5'd0, 5'd0, 5'b01001, 1'b0, 1'b0);
        run_instr("ba",       2'b00, 6'd0, 5'd0, 5'd0, 5'b01000, 1'b0, 1'b1);
        run_instr("bn",       2'b00, 6'd0, 5'd0, 5'd0, 5'b00000, 1'b0, 1'b0);
        run_instr("subcc_nz", 2'b10, 6'b010000, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0);
        run_instr("be_nt",    2'b00, 6'd0, 5'd0, 5'd0, 5'b00001, 1'b0, 1'b0);
        c_n = 1'b0;
        run_instr("addcc_c",  2'b10, 6'b010101, 5'd7, 5'd8, 5'd9, 1'b1, 1'b0);
        c_n = 1'b1; v_n = 1'b0;
        run_instr("add_nocc", 2'b10, 6'b000011, 5'd31, 5'd30, 5'd29, 1'b0, 1'b0);
        v_n = 1'b1;
        run_instr("bcs_t",    2'b00, 6'd0, 5'd0, 5'd0, 5'b00101, 1'b0, 1'b1);
        run_instr("bvs_nt",   2'b00, 6'd0, 5'd0, 5'd0, 5'b00111, 1'b0, 1'b0);
        run_instr("bneg_nt",  2'b00, 6'd0, 5'd0, 5'd0, 5'b00110, 1'b0, 1'b0);
        run_instr("bundef",   2'b00, 6'd0, 5'd0, 5'd0, 5'b00010, 1'b0, 1'b0);
        z_n = 1'b0;
        run_instr("subcc_z2", 2'b10, 6'b010000, 5'd1, 5'd1, 5'd0, 1'b0, 1'b0);
        z_n = 1'b1;

        run_instr("ill01",    2'b01, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        run_instr("post_ill", 2'b10, 6'b000001, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0);
        run_instr("ill11",    2'b11, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // Reset mid-instruction while in EXEC_ALU.
        op = 2'b10; op3 = 6'b000000; rs1 = 5'd5; rs2 = 5'd6; rd = 5'd7; bit13 = 1'b0;
        cyc(mk("rst_exec.fetch", 3'd1, 6'd0, 6'd32, 6'd0, 4'hF, 1'b0));
        cyc(idle("rst_exec.decode", 3'd2));
        rst_n = 1'b0;
        cyc(mk("rst_exec.exec", 3'd3, 6'd0, 6'd5, 6'd6, 4'h0, 1'b1));
        rst_n = 1'b1;
        exp_ill = 1'b0;
        cyc(idle("rst_exec.wait", 3'd0));
        run_instr("be_clr",   2'b00, 6'd0, 5'd0, 5'd0, 5'b00001, 1'b0, 1'b0);

        // Single-step: the switch takes effect at the PCLOAD decision.
        single = 1'b1;
        run_instr("bne_ss",   2'b00, 6'd0, 5'd0, 5'd0, 5'b01001, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc(idle($sformatf("ss_hold%0d", i), 3'd0));
        step_n = 1'b0;
        cyc(idle("ss_step", 3'd0));
        step_n = 1'b1;
        run_instr("ss_one",   2'b10, 6'b000010, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(idle($sformatf("ss_back%0d", i), 3'd0));
        step_n = 1'b0;
        cyc(idle("ss_cont0", 3'd0));
        run_instr("ss_c1",    2'b10, 6'b000000, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0);
        cyc(idle("ss_cont1", 3'd0));
        run_instr("ss_c2",    2'b00, 6'd0, 5'd0, 5'd0, 5'b01000, 1'b0, 1'b1);
        cyc(idle("ss_cont2", 3'd0));

        // Reset in INCPC with step held low: no PC write, back to WAIT.
        op = 2'b10; op3 = 6'b000000; rs1 = 5'd1; rs2 = 5'd1; rd = 5'd1;
        cyc(mk("rst_inc.fetch", 3'd1, 6'd0, 6'd32, 6'd0, 4'hF, 1'b0));
        cyc(idle("rst_inc.decode", 3'd2));
        cyc(mk("rst_inc.exec", 3'd3, 6'd1, 6'd1, 6'd1, 4'h0, 1'b1));
        rst_n = 1'b0;
        cyc(mk("rst_inc.incpc", 3'd5, 6'd0, 6'd32, 6'd33, 4'h0, 1'b1));
        rst_n = 1'b1; single = 1'b0; step_n = 1'b1;
        cyc(idle("rst_inc.wait", 3'd0));
        run_instr("final",    2'b10, 6'b000100, 5'd9, 5'd10, 5'd11, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
